// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//   Shares one combinational multi-function ALU between two requesters.
//   A round-robin arbiter picks a requester in IDLE and latches its operands
//   and function select. The matching one-hot enable is then held for LAT
//   cycles, the ALU answer is captured, and the result is returned on a
//   valid/ready response channel tagged with the requester id.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req0_* / req1_*         requester channels: valid/ready handshake plus
//                           function select (op) and operands (a, b)
//   alu_a, alu_b, alu_en    operands and one-hot function enable to the ALU
//   alu_ans                 ALU result (OR of enabled function outputs)
//   rsp_valid/ready/id/data result channel back to the requesters
//   busy                    high whenever the scheduler is not in IDLE
module alu_op_scheduler #(
  parameter int WIDTH = 4,
  parameter int NFUNC = 16,
  parameter int LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [$clog2(NFUNC)-1:0] req0_op,
  input  logic [WIDTH-1:0]         req0_a,
  input  logic [WIDTH-1:0]         req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [$clog2(NFUNC)-1:0] req1_op,
  input  logic [WIDTH-1:0]         req1_a,
  input  logic [WIDTH-1:0]         req1_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [NFUNC-1:0]         alu_en,
  input  logic [WIDTH-1:0]         alu_ans,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int OPW = $clog2(NFUNC);
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);
  localparam logic [NFUNC-1:0] EN_ONE = {{(NFUNC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ptr_q;      // 0: req0 wins a tie, 1: req1 wins a tie
  logic             id_q;
  logic [3:0]       cnt_q;
  logic             gnt0;
  logic             gnt1;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Arbitration and next-state decode
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || !ptr_q)) begin
          gnt0 = 1'b1;
        end else if (req1_valid) begin
          gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign sel_op     = gnt1 ? req1_op : req0_op;
  assign sel_a      = gnt1 ? req1_a  : req0_a;
  assign sel_b      = gnt1 ? req1_b  : req0_b;
  assign busy       = (state_q != IDLE);

  // Grant latch -> EXEC hold -> result capture -> response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      cnt_q     <= 4'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_en    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          alu_en <= '0;
          if (gnt0 || gnt1) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_en <= EN_ONE << sel_op;
            id_q   <= gnt1;
            // Next tie goes to whoever did not win this one
            ptr_q  <= gnt0;
            cnt_q  <= CNT_LOAD;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            rsp_data  <= alu_ans;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            alu_en    <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
module tb_alu_op_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural ALU: each enabled function contributes, results ORed.
  function automatic logic [3:0] alu_fn(input logic [15:0] en, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = 4'h0;
    if (en[0])  r = r | (a & b);
    if (en[1])  r = r | (a | b);
    if (en[2])  r = r | (a ^ b);
    if (en[3])  r = r | (a + b);
    if (en[4])  r = r | (a - b);
    if (en[5])  r = r | (~a);
    if (en[6])  r = r | a;
    if (en[7])  r = r | b;
    if (en[8])  r = r | ~(a & b);
    if (en[9])  r = r | ~(a ^ b);
    if (en[10]) r = r | ~(a | b);
    if (en[11]) r = r | (a << 1);
    if (en[12]) r = r | (a >> 1);
    if (en[13]) r = r | (a + 4'd1);
    if (en[14]) r = r | (a - 4'd1);
    if (en[15]) r = r | (b - a);
    return r;
  endfunction

  // Instance with LAT=1
  logic        r0v, r0r, r1v, r1r;
  logic [3:0]  r0op, r0a, r0b, r1op, r1a, r1b;
  logic [3:0]  alu_a, alu_b, alu_ans, rsp_data;
  logic [15:0] alu_en;
  logic        rsp_valid, rsp_ready, rsp_id, busy;

  assign alu_ans = alu_fn(alu_en, alu_a, alu_b);

  alu_op_scheduler #(.WIDTH(4), .NFUNC(16), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en), .alu_ans(alu_ans),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  // Instance with LAT=3
  logic        t_r0v, t_r0r, t_r1v, t_r1r;
  logic [3:0]  t_r0op, t_r0a, t_r0b, t_r1op, t_r1a, t_r1b;
  logic [3:0]  t_alu_a, t_alu_b, t_alu_ans, t_rsp_data;
  logic [15:0] t_alu_en;
  logic        t_rsp_valid, t_rsp_ready, t_rsp_id, t_busy;

  assign t_alu_ans = alu_fn(t_alu_en, t_alu_a, t_alu_b);

  alu_op_scheduler #(.WIDTH(4), .NFUNC(16), .LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t_r0v), .req0_ready(t_r0r), .req0_op(t_r0op), .req0_a(t_r0a), .req0_b(t_r0b),
    .req1_valid(t_r1v), .req1_ready(t_r1r), .req1_op(t_r1op), .req1_a(t_r1a), .req1_b(t_r1b),
    .alu_a(t_alu_a), .alu_b(t_alu_b), .alu_en(t_alu_en), .alu_ans(t_alu_ans),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id), .rsp_data(t_rsp_data),
    .busy(t_busy)
  );

  task automatic test_reset();
    #2;
    total++; if (alu_en !== 16'h0) begin bad++; $display("FAIL rst_alu_en got=%h want=0000", alu_en); end
    total++; if (alu_a !== 4'h0 || alu_b !== 4'h0) begin bad++; $display("FAIL rst_alu_ab got=%h/%h want=0/0", alu_a, alu_b); end
    total++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 4'h0) begin bad++; $display("FAIL rst_rsp got=%b/%b/%h want=0/0/0", rsp_valid, rsp_id, rsp_data); end
    total++; if (busy !== 1'b0 || r0r !== 1'b0 || r1r !== 1'b0) begin bad++; $display("FAIL rst_ctrl got busy=%b rdy=%b%b want 0 00", busy, r0r, r1r); end
    total++; if (t_alu_en !== 16'h0 || t_busy !== 1'b0) begin bad++; $display("FAIL rst_lat3 got en=%h busy=%b want 0000 0", t_alu_en, t_busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    r0v = 1'b1; r0op = 4'd9; r0a = 4'b1010; r0b = 4'b0110; rsp_ready = 1'b1;
    #1;
    total++; if (r0r !== 1'b1 || r1r !== 1'b0) begin bad++; $display("FAIL single_grant got rdy=%b%b want 10", r0r, r1r); end
    @(negedge clk);
    r0v = 1'b0;
    #1;
    total++; if (alu_en !== 16'h0200) begin bad++; $display("FAIL single_en got=%h want=0200", alu_en); end
    total++; if (alu_a !== 4'b1010 || alu_b !== 4'b0110) begin bad++; $display("FAIL single_ops got=%b/%b want 1010/0110", alu_a, alu_b); end
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec got busy=%b vld=%b want 1 0", busy, rsp_valid); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 4'b0011 || rsp_id !== 1'b0) begin bad++; $display("FAIL single_rsp got vld=%b data=%b id=%b want 1 0011 0", rsp_valid, rsp_data, rsp_id); end
    total++; if (alu_en !== 16'h0) begin bad++; $display("FAIL single_en_off got=%h want=0000", alu_en); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_done got vld=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    r0v = 1'b1; r0op = 4'd5; r0a = 4'h3; r0b = 4'h1;
    @(negedge clk);
    r0v = 1'b0;
    #1;
    total++; if (alu_en !== 16'h0020) begin bad++; $display("FAIL midrst_pre got en=%h want=0020", alu_en); end
    rst_n = 1'b0;
    #1;
    total++; if (alu_en !== 16'h0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_async got en=%h vld=%b busy=%b want 0000 0 0", alu_en, rsp_valid, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    r0v = 1'b1; r1v = 1'b1; r1op = 4'd1; r1a = 4'h1; r1b = 4'h2;
    #1;
    total++; if (r0r !== 1'b1 || r1r !== 1'b0) begin bad++; $display("FAIL midrst_ptr got rdy=%b%b want 10", r0r, r1r); end
    r0v = 1'b0; r1v = 1'b0;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_noresp got busy=%b vld=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_contention();
    logic e0, e1, eid;
    r0op = 4'd3; r0a = 4'h1; r0b = 4'h2;   // ADD -> 3
    r1op = 4'd2; r1a = 4'h5; r1b = 4'h3;   // XOR -> 6
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin r0v = 1'b1; r1v = 1'b1; end
      #1;
      e0  = (k % 3 == 0) && ((k / 3) % 2 == 0);
      e1  = (k % 3 == 0) && ((k / 3) % 2 == 1);
      eid = ((k / 3) % 2 == 1);
      total++; if (r0r !== e0 || r1r !== e1) begin bad++; $display("FAIL contend_grant k=%0d got rdy=%b%b want %b%b", k, r0r, r1r, e0, e1); end
      if (k % 3 == 2) begin
        total++; if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== (eid ? 4'h6 : 4'h3)) begin bad++; $display("FAIL contend_rsp k=%0d got vld=%b id=%b data=%h want 1 %b %h", k, rsp_valid, rsp_id, rsp_data, eid, eid ? 4'h6 : 4'h3); end
      end else begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL contend_novld k=%0d got vld=%b want 0", k, rsp_valid); end
      end
      if (k == 11) begin r0v = 1'b0; r1v = 1'b0; end
    end
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL contend_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    r1v = 1'b1; r1op = 4'd1; r1a = 4'h9; r1b = 4'h4;   // OR -> D
    rsp_ready = 1'b0;
    #1;
    total++; if (r1r !== 1'b1 || r0r !== 1'b0) begin bad++; $display("FAIL bp_grant got rdy=%b%b want 01", r0r, r1r); end
    @(negedge clk);
    r0v = 1'b1; r0a = 4'h7;
    #1;
    total++; if (alu_en !== 16'h0002 || r0r !== 1'b0 || r1r !== 1'b0) begin bad++; $display("FAIL bp_exec got en=%h rdy=%b%b want 0002 00", alu_en, r0r, r1r); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 4'hD || rsp_id !== 1'b1) begin bad++; $display("FAIL bp_hold i=%0d got vld=%b data=%h id=%b want 1 d 1", i, rsp_valid, rsp_data, rsp_id); end
      total++; if (r0r !== 1'b0 || r1r !== 1'b0) begin bad++; $display("FAIL bp_noready i=%0d got rdy=%b%b want 00", i, r0r, r1r); end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got vld=%b want 0", rsp_valid); end
    total++; if (r0r !== 1'b1 || r1r !== 1'b0) begin bad++; $display("FAIL bp_next_ptr got rdy=%b%b want 10", r0r, r1r); end
    r0v = 1'b0; r1v = 1'b0;
  endtask

  task automatic test_operand_hold();
    @(negedge clk);
    r0v = 1'b1; r0op = 4'd6; r0a = 4'h5; r0b = 4'h0;   // pass A
    @(posedge clk); #1;
    r0a = 4'hC; r0op = 4'd7; r0v = 1'b0;
    @(negedge clk); #1;
    total++; if (alu_a !== 4'h5 || alu_en !== 16'h0040) begin bad++; $display("FAIL hold_exec got a=%h en=%h want 5 0040", alu_a, alu_en); end
    @(negedge clk); #1;
    total++; if (rsp_data !== 4'h5 || alu_a !== 4'h5 || rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_rsp got data=%h a=%h vld=%b want 5 5 1", rsp_data, alu_a, rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_lat3();
    @(negedge clk);
    t_r1v = 1'b1; t_r1op = 4'd0; t_r1a = 4'hF; t_r1b = 4'h3; t_rsp_ready = 1'b1;
    #1;
    total++; if (t_r1r !== 1'b1 || t_r0r !== 1'b0) begin bad++; $display("FAIL lat3_grant got rdy=%b%b want 01", t_r0r, t_r1r); end
    @(negedge clk);
    t_r1v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      total++; if (t_alu_en !== 16'h0001 || t_rsp_valid !== 1'b0) begin bad++; $display("FAIL lat3_exec i=%0d got en=%h vld=%b want 0001 0", i, t_alu_en, t_rsp_valid); end
    end
    @(negedge clk); #1;
    total++; if (t_alu_en !== 16'h0 || t_rsp_valid !== 1'b1 || t_rsp_data !== 4'h3 || t_rsp_id !== 1'b1) begin bad++; $display("FAIL lat3_rsp got en=%h vld=%b data=%h id=%b want 0000 1 3 1", t_alu_en, t_rsp_valid, t_rsp_data, t_rsp_id); end
    @(negedge clk); #1;
    total++; if (t_rsp_valid !== 1'b0 || t_busy !== 1'b0) begin bad++; $display("FAIL lat3_done got vld=%b busy=%b want 0 0", t_rsp_valid, t_busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    r0v = 1'b0; r0op = 4'h0; r0a = 4'h0; r0b = 4'h0;
    r1v = 1'b0; r1op = 4'h0; r1a = 4'h0; r1b = 4'h0;
    rsp_ready = 1'b1;
    t_r0v = 1'b0; t_r0op = 4'h0; t_r0a = 4'h0; t_r0b = 4'h0;
    t_r1v = 1'b0; t_r1op = 4'h0; t_r1a = 4'h0; t_r1b = 4'h0;
    t_rsp_ready = 1'b1;
    test_reset();
    test_single_op();
    test_reset_mid_exec();
    test_contention();
    test_backpressure();
    test_operand_hold();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
